vga_rect_compositor: RTL and testbench
======================================

Name: vga_rect_compositor

Overview:
- Parametrised successor to the single-rectangle renderer; composites NUM_RECTS independently placed, sized and coloured rectangles over a background colour.
- Sits between the VGA timing generator and the pin drivers.
- Geometry is double-buffered and latched once per frame, so game logic may update positions at any time without tearing.
- Fixed 2-cycle pixel pipeline; syncs are delayed to match.

Parameters:
NUM_RECTS, 3, number of rectangles (1..8); index 0 has highest priority
COLOR_BITS, 3, bits per colour channel
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows

Ports:
i_CLK  in  1  pixel clock
i_RST  in  1  synchronous, active-high reset
i_hSync  in  1  hsync from timing generator
i_vSync  in  1  vsync from timing generator
i_display_x_pos  in  10  current pixel column
i_display_y_pos  in  10  current pixel row
i_rect_x_pos  in  10*NUM_RECTS  packed left edges; rect k at [10k+9:10k]
i_rect_y_pos  in  10*NUM_RECTS  packed top edges
i_rect_w  in  10*NUM_RECTS  packed widths
i_rect_h  in  10*NUM_RECTS  packed heights
i_rect_en  in  NUM_RECTS  per-rect enable
i_rect_color  in  3*COLOR_BITS*NUM_RECTS  packed {R,G,B} per rect
i_bg_color  in  3*COLOR_BITS  {R,G,B} for in-screen non-rect pixels
o_red  out  COLOR_BITS  red
o_green  out  COLOR_BITS  green
o_blue  out  COLOR_BITS  blue
o_hSync  out  1  hsync delayed 2 cycles
o_vSync  out  1  vsync delayed 2 cycles
o_frame_start  out  1  one-cycle pulse when shadow geometry is latched
o_collision  out  NUM_RECTS  per-frame overlap flags (see Optional Feature)

Behaviour:
- Reset (i_RST high at a clock edge):
  - o_red, o_green, o_blue, o_frame_start, o_collision all 0.
  - o_hSync and o_vSync 1 (inactive; syncs are active-low).
  - All shadow registers 0, including enables, so nothing is drawn.
  - Pipeline registers cleared.
- Latch point is the cycle where i_display_x_pos==0 and i_display_y_pos==V_ACTIVE (start of vertical blanking).
  - On that cycle, all i_rect_* and i_bg_color inputs are copied into shadow registers.
  - o_frame_start is 1 on the following cycle only.
  - Input changes at any other time have no visible effect until the next latch point.
- Reset mid-frame: shadow registers are cleared; output is black (outside screen) or background 0 until the first latch after reset.
- Stage 1 (registered):
  - Per rect k, hit_k = en_k && x >= X_k && x < X_k+W_k && y >= Y_k && y < Y_k+H_k.
  - Sums are computed 11 bits wide, so there is no wrap; a rect extending past 1023 is clipped, never wrapped to the left edge.
  - Left and top edges are inclusive; right and bottom are exclusive. W=0 or H=0 never draws.
  - Flag onscreen = (x < H_ACTIVE && y < V_ACTIVE).
- Stage 2 (registered):
  - If not onscreen, output 0,0,0.
  - Else, colour of the lowest-index k with hit_k set.
  - Else, shadow background colour.
- Latency: colour for the pixel presented at cycle n appears at cycle n+2. o_hSync/o_vSync equal i_hSync/i_vSync from 2 cycles earlier.
- Rectangles may overlap; priority is strictly by index; non-enabled rects never win.

Optional Feature:
- Macro: VGA_RECT_COMPOSITOR_COLLISION_EN.
- Defined:
  - A per-frame accumulator bit k (k>=1) is set when hit_0 and hit_k are both true on the same onscreen pixel.
  - At each latch point the accumulator is copied to o_collision and cleared. o_collision holds for one full frame.
  - If a collision pixel coincides with the latch cycle, that pixel counts toward the new frame.
  - o_collision[0] is always 0.
- Not defined: o_collision is constant 0; no accumulator logic is synthesised.

Test Plan:
- Reset, then run one frame with all enables 1, x=100, y=50, w=15, h=100 latched.
  - Before the latch, all pixels are bg/black.
  - After the latch, pixel (100,50) shows rect colour 2 cycles later; (115,50) and (100,150) show background; (99,50) shows background.
- Latency/sync: toggle i_hSync at a known cycle -> o_hSync toggles exactly 2 cycles later; the colour change at rect edge x=100 is aligned with the same delay.
- Priority: rect0 red at (200,200,20,20), rect1 green at (210,210,20,20).
  - Pixel (215,215) is red; (225,225) is green.
  - Disable rect0 -> (215,215) is green after the next latch.
- Tearing: change i_rect_x_pos mid-frame at y=240 -> no pixel change in the current frame; new position appears only after the o_frame_start pulse.
- Boundaries:
  - x_pos=1020, w=15 -> no pixel drawn at x=0..10.
  - w=0 -> never drawn.
  - Pixels at x>=640 or y>=480 are 0 regardless of bg.
- COLLISION_EN: rect0 at (300,300,10,10), rect2 at (305,305,10,10) -> o_collision==3'b100 for the frame after the overlap; move rect2 away -> 3'b000 one frame later.

Source files
------------

// File: rtl/vga_rect_compositor_if.sv
// Pixel-stream bundle between the VGA timing generator, the rectangle
// compositor and the pin drivers.
// Flow control: none. One pixel position is presented on every i_CLK cycle.
// It is always accepted, and one colour leaves two cycles later.
// There is no valid/ready pair because the raster never stalls.
interface vga_rect_compositor_if #(
    parameter int NUM_RECTS  = 3,
    parameter int COLOR_BITS = 3
);
    // timing generator side
    logic                              i_hSync;
    logic                              i_vSync;
    logic [9:0]                        i_display_x_pos;
    logic [9:0]                        i_display_y_pos;
    // game-logic geometry (live values, latched once per frame)
    logic [10*NUM_RECTS-1:0]           i_rect_x_pos;
    logic [10*NUM_RECTS-1:0]           i_rect_y_pos;
    logic [10*NUM_RECTS-1:0]           i_rect_w;
    logic [10*NUM_RECTS-1:0]           i_rect_h;
    logic [NUM_RECTS-1:0]              i_rect_en;
    logic [3*COLOR_BITS*NUM_RECTS-1:0] i_rect_color;
    logic [3*COLOR_BITS-1:0]           i_bg_color;
    // pin-driver side
    logic [COLOR_BITS-1:0]             o_red;
    logic [COLOR_BITS-1:0]             o_green;
    logic [COLOR_BITS-1:0]             o_blue;
    logic                              o_hSync;
    logic                              o_vSync;
    logic                              o_frame_start;
    logic [NUM_RECTS-1:0]              o_collision;

    modport master (
        output i_hSync, i_vSync, i_display_x_pos, i_display_y_pos,
        output i_rect_x_pos, i_rect_y_pos, i_rect_w, i_rect_h,
        output i_rect_en, i_rect_color, i_bg_color,
        input  o_red, o_green, o_blue, o_hSync, o_vSync,
        input  o_frame_start, o_collision
    );

    modport slave (
        input  i_hSync, i_vSync, i_display_x_pos, i_display_y_pos,
        input  i_rect_x_pos, i_rect_y_pos, i_rect_w, i_rect_h,
        input  i_rect_en, i_rect_color, i_bg_color,
        output o_red, o_green, o_blue, o_hSync, o_vSync,
        output o_frame_start, o_collision
    );
endinterface

// File: rtl/vga_rect_compositor.sv
// Composites NUM_RECTS rectangles over a background colour.
// Geometry is shadowed once per frame at the start of vertical blanking.
// The pixel path is two registered stages: hit test, then priority select.
// Syncs travel through the same two stages.
// Optional macro VGA_RECT_COMPOSITOR_COLLISION_EN adds per-frame overlap
// flags between rect 0 and every other rect. Without it, o_collision is 0.
module vga_rect_compositor #(
    parameter int NUM_RECTS  = 3,
    parameter int COLOR_BITS = 3,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input logic                  i_CLK,
    input logic                  i_RST,
    vga_rect_compositor_if.slave bus
);
    localparam int CW = 3 * COLOR_BITS;

    // Latch point: first cycle of vertical blanking.
    logic latch;
    assign latch = (bus.i_display_x_pos == 10'd0) &&
                   (bus.i_display_y_pos == 10'(V_ACTIVE));

    logic [10*NUM_RECTS-1:0] sh_x;
    logic [10*NUM_RECTS-1:0] sh_y;
    logic [10*NUM_RECTS-1:0] sh_w;
    logic [10*NUM_RECTS-1:0] sh_h;
    logic [NUM_RECTS-1:0]    sh_en;
    logic [CW*NUM_RECTS-1:0] sh_color;
    logic [CW-1:0]           sh_bg;
    logic                    frame_start_q;

    // Shadow geometry: copy live inputs only at the latch point.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            sh_x          <= '0;
            sh_y          <= '0;
            sh_w          <= '0;
            sh_h          <= '0;
            sh_en         <= '0;
            sh_color      <= '0;
            sh_bg         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= latch;
            if (latch) begin
                sh_x     <= bus.i_rect_x_pos;
                sh_y     <= bus.i_rect_y_pos;
                sh_w     <= bus.i_rect_w;
                sh_h     <= bus.i_rect_h;
                sh_en    <= bus.i_rect_en;
                sh_color <= bus.i_rect_color;
                sh_bg    <= bus.i_bg_color;
            end
        end
    end

    // Stage 1 combinational hit test.
    // The edges are widened to 11 bits so that X+W cannot wrap.
    logic [10:0]          px11;
    logic [10:0]          py11;
    logic [NUM_RECTS-1:0] hit_c;
    logic                 onscreen_c;

    assign px11 = {1'b0, bus.i_display_x_pos};
    assign py11 = {1'b0, bus.i_display_y_pos};

    // Per-rect containment check: left/top inclusive, right/bottom exclusive.
    always_comb begin
        hit_c = '0;
        for (int k = 0; k < NUM_RECTS; k++) begin
            hit_c[k] = sh_en[k] &&
                (px11 >= {1'b0, sh_x[10*k +: 10]}) &&
                (px11 <  ({1'b0, sh_x[10*k +: 10]} + {1'b0, sh_w[10*k +: 10]})) &&
                (py11 >= {1'b0, sh_y[10*k +: 10]}) &&
                (py11 <  ({1'b0, sh_y[10*k +: 10]} + {1'b0, sh_h[10*k +: 10]}));
        end
    end

    assign onscreen_c = (bus.i_display_x_pos < 10'(H_ACTIVE)) &&
                        (bus.i_display_y_pos < 10'(V_ACTIVE));

    logic [NUM_RECTS-1:0] s1_hit;
    logic                 s1_on;
    logic                 s1_hs;
    logic                 s1_vs;

    // Stage 1 register: hit vector, onscreen flag, syncs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            s1_hit <= '0;
            s1_on  <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
        end else begin
            s1_hit <= hit_c;
            s1_on  <= onscreen_c;
            s1_hs  <= bus.i_hSync;
            s1_vs  <= bus.i_vSync;
        end
    end

    // Stage 2 combinational priority select.
    // The loop walks from the highest index down, so the lowest index wins.
    logic [CW-1:0] pix_c;
    always_comb begin
        pix_c = sh_bg;
        for (int k = NUM_RECTS - 1; k >= 0; k--) begin
            if (s1_hit[k]) begin
                pix_c = sh_color[CW*k +: CW];
            end
        end
        if (!s1_on) begin
            pix_c = '0;
        end
    end

    logic [CW-1:0] s2_pix;
    logic          s2_hs;
    logic          s2_vs;

    // Stage 2 register: final colour and syncs to the pins.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            s2_pix <= '0;
            s2_hs  <= 1'b1;
            s2_vs  <= 1'b1;
        end else begin
            s2_pix <= pix_c;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    assign bus.o_red         = s2_pix[3*COLOR_BITS-1 -: COLOR_BITS];
    assign bus.o_green       = s2_pix[2*COLOR_BITS-1 -: COLOR_BITS];
    assign bus.o_blue        = s2_pix[COLOR_BITS-1:0];
    assign bus.o_hSync       = s2_hs;
    assign bus.o_vSync       = s2_vs;
    assign bus.o_frame_start = frame_start_q;

`ifdef VGA_RECT_COMPOSITOR_COLLISION_EN
    logic [NUM_RECTS-1:0] coll_now;
    logic [NUM_RECTS-1:0] coll_acc;
    logic [NUM_RECTS-1:0] coll_q;

    // Overlap with rect 0 on the onscreen pixel currently in stage 1.
    always_comb begin
        coll_now = '0;
        for (int k = 1; k < NUM_RECTS; k++) begin
            coll_now[k] = s1_on && s1_hit[0] && s1_hit[k];
        end
    end

    // Per-frame accumulator.
    // At the latch point it is published, then restarted with the pixel
    // that is evaluated on that same cycle.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            coll_acc <= '0;
            coll_q   <= '0;
        end else if (latch) begin
            coll_q   <= coll_acc;
            coll_acc <= coll_now;
        end else begin
            coll_acc <= coll_acc | coll_now;
        end
    end

    assign bus.o_collision = coll_q;
`else
    assign bus.o_collision = '0;
`endif
endmodule

// File: tb/tb_vga_rect_compositor.sv
// Bench for vga_rect_compositor: table vectors, hand sequences, random pixels.
module tb_vga_rect_compositor;
    localparam int NR = 3;
    localparam int CB = 3;
    localparam int CW = 3 * CB;
    localparam int HA = 640;
    localparam int VA = 480;

    localparam logic [CW-1:0] RED   = 9'b111_000_000;
    localparam logic [CW-1:0] GREEN = 9'b000_111_000;
    localparam logic [CW-1:0] BLUE  = 9'b000_000_111;
    localparam logic [CW-1:0] BG    = 9'b001_010_011;
    localparam logic [CW-1:0] C0    = 9'b101_110_101;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rect_compositor_if #(.NUM_RECTS(NR), .COLOR_BITS(CB)) bus ();

    vga_rect_compositor #(
        .NUM_RECTS(NR), .COLOR_BITS(CB), .H_ACTIVE(HA), .V_ACTIVE(VA)
    ) dut (
        .i_CLK(clk),
        .i_RST(rst),
        .bus  (bus)
    );

    // live geometry held by the bench
    int            rx [NR];
    int            ry [NR];
    int            rw [NR];
    int            rh [NR];
    bit            ren[NR];
    logic [CW-1:0] rcol[NR];
    logic [CW-1:0] bg;

    // reference model state: geometry as of the last latch, collision flags
    int            mx [NR];
    int            my [NR];
    int            mw [NR];
    int            mh [NR];
    bit            men[NR];
    logic [CW-1:0] mcol[NR];
    logic [CW-1:0] mbg;
    logic [NR-1:0] m_acc;
    logic [NR-1:0] m_coll;

    // scoreboard: {rgb, hsync, vsync} expected two cycles after issue
    logic [CW+1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    typedef struct {
        int            x;
        int            y;
        logic [CW-1:0] rgb;
    } vec_t;
    vec_t vt[$];

    function automatic bit in_rect(int k, int x, int y);
        return men[k] && x >= mx[k] && x < mx[k] + mw[k] &&
               y >= my[k] && y < my[k] + mh[k];
    endfunction

    function automatic logic [CW-1:0] model_pixel(int x, int y);
        if (x >= HA || y >= VA) return '0;
        for (int k = 0; k < NR; k++) begin
            if (in_rect(k, x, y)) return mcol[k];
        end
        return mbg;
    endfunction

    function automatic logic [NR-1:0] model_coll(int x, int y);
        logic [NR-1:0] r;
        r = '0;
`ifdef VGA_RECT_COMPOSITOR_COLLISION_EN
        if (x < HA && y < VA && in_rect(0, x, y)) begin
            for (int k = 1; k < NR; k++) begin
                if (in_rect(k, x, y)) r[k] = 1'b1;
            end
        end
`else
        if (x < 0 || y < 0) r = '0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NR; k++) begin
            mx[k] = 0; my[k] = 0; mw[k] = 0; mh[k] = 0; men[k] = 0; mcol[k] = '0;
        end
        mbg    = '0;
        m_acc  = '0;
        m_coll = '0;
    endtask

    task automatic set_rect(input int k, input int x, input int y, input int w,
                            input int h, input bit en, input logic [CW-1:0] c);
        rx[k] = x; ry[k] = y; rw[k] = w; rh[k] = h; ren[k] = en; rcol[k] = c;
    endtask

    // driver: present the live geometry on the bus
    task automatic apply_inputs();
        logic [10*NR-1:0] px, py, pw, ph;
        logic [CW*NR-1:0] pc;
        logic [NR-1:0]    pe;
        for (int k = 0; k < NR; k++) begin
            px[10*k +: 10] = 10'(rx[k]);
            py[10*k +: 10] = 10'(ry[k]);
            pw[10*k +: 10] = 10'(rw[k]);
            ph[10*k +: 10] = 10'(rh[k]);
            pc[CW*k +: CW] = rcol[k];
            pe[k]          = ren[k];
        end
        bus.i_rect_x_pos = px;
        bus.i_rect_y_pos = py;
        bus.i_rect_w     = pw;
        bus.i_rect_h     = ph;
        bus.i_rect_en    = pe;
        bus.i_rect_color = pc;
        bus.i_bg_color   = bg;
    endtask

    // driver: one pixel per clock; checks the pixel issued two steps earlier
    task automatic step(input int x, input int y, input bit hs, input bit vs,
                        input bit use_exp, input logic [CW-1:0] exp_rgb);
        bit            is_latch;
        logic [CW-1:0] e;
        logic [CW+1:0] got;
        bus.i_display_x_pos = 10'(x);
        bus.i_display_y_pos = 10'(y);
        bus.i_hSync         = hs;
        bus.i_vSync         = vs;
        is_latch = (x == 0 && y == VA);
        e = use_exp ? exp_rgb : model_pixel(x, y);
        exp_q.push_back({e, hs, vs});
        if (is_latch) begin
            m_coll = m_acc;
            m_acc  = '0;
            for (int k = 0; k < NR; k++) begin
                mx[k] = rx[k]; my[k] = ry[k]; mw[k] = rw[k]; mh[k] = rh[k];
                men[k] = ren[k]; mcol[k] = rcol[k];
            end
            mbg = bg;
        end else begin
            m_acc = m_acc | model_coll(x, y);
        end
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            got = exp_q.pop_front();
            check("pixel", {bus.o_red, bus.o_green, bus.o_blue, bus.o_hSync, bus.o_vSync}, got);
        end
        check("frame_start", bus.o_frame_start, is_latch);
        check("collision", bus.o_collision, m_coll);
    endtask

    task automatic pxm(input int x, input int y);
        step(x, y, 1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic pxe(input int x, input int y, input logic [CW-1:0] rgb);
        step(x, y, 1'b1, 1'b1, 1'b1, rgb);
    endtask

    // offscreen filler, then the latch pixel
    task automatic do_latch();
        pxm(700, 479);
        pxm(0, VA);
    endtask

    task automatic run_table();
        for (int i = 0; i < vt.size(); i++) begin
            pxe(vt[i].x, vt[i].y, vt[i].rgb);
        end
        vt.delete();
    endtask

    task automatic add(input int x, input int y, input logic [CW-1:0] rgb);
        vec_t v;
        v.x = x; v.y = y; v.rgb = rgb;
        vt.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_display_x_pos = 10'd5;
        bus.i_display_y_pos = 10'd5;
        @(posedge clk);
        @(negedge clk);
        check("reset_rgb", {bus.o_red, bus.o_green, bus.o_blue}, 0);
        check("reset_syncs", {bus.o_hSync, bus.o_vSync}, 2'b11);
        check("reset_frame_start", bus.o_frame_start, 0);
        check("reset_collision", bus.o_collision, 0);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
    endtask

    initial begin
        for (int k = 0; k < NR; k++) set_rect(k, 0, 0, 0, 0, 1'b0, '0);
        bg = '0;
        apply_inputs();
        bus.i_hSync = 1'b1;
        bus.i_vSync = 1'b1;
        bus.i_display_x_pos = 10'd5;
        bus.i_display_y_pos = 10'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // basic placement, all enables on
        set_rect(0, 100, 50, 15, 100, 1'b1, C0);
        set_rect(1, 600, 400, 10, 10, 1'b1, GREEN);
        set_rect(2, 0, 0, 0, 5, 1'b1, BLUE);
        bg = BG;
        apply_inputs();
        add(100, 50, '0); add(300, 300, '0); add(101, 51, '0);
        run_table();
        do_latch();
        add(100, 50, C0);  add(115, 50, BG);   add(100, 150, BG); add(99, 50, BG);
        add(114, 149, C0); add(605, 405, GREEN); add(0, 0, BG);   add(640, 50, '0);
        add(100, 480, '0); add(610, 405, BG);
        run_table();

        // latency: sync edge and rect edge land two cycles later together
        step(99, 60, 1'b1, 1'b1, 1'b1, BG);
        step(100, 60, 1'b0, 1'b1, 1'b1, C0);
        check("hsync_after_1", bus.o_hSync, 1);
        check("rgb_after_1", {bus.o_red, bus.o_green, bus.o_blue}, BG);
        step(101, 60, 1'b0, 1'b0, 1'b1, C0);
        check("hsync_after_2", bus.o_hSync, 0);
        check("rgb_after_2", {bus.o_red, bus.o_green, bus.o_blue}, C0);
        step(102, 60, 1'b1, 1'b1, 1'b1, C0);
        check("vsync_after_2", bus.o_vSync, 0);

        // priority
        set_rect(0, 200, 200, 20, 20, 1'b1, RED);
        set_rect(1, 210, 210, 20, 20, 1'b1, GREEN);
        set_rect(2, 0, 0, 0, 0, 1'b1, BLUE);
        apply_inputs();
        do_latch();
        add(215, 215, RED); add(225, 225, GREEN); add(205, 205, RED); add(228, 205, BG);
        add(219, 219, RED); add(220, 220, GREEN); add(229, 229, GREEN); add(230, 230, BG);
        run_table();
        ren[0] = 1'b0;
        apply_inputs();
        add(215, 215, RED);
        run_table();
        do_latch();
        add(215, 215, GREEN); add(205, 205, BG);
        run_table();

        // tearing: a mid-frame move stays invisible until the next latch
        set_rect(0, 100, 200, 20, 100, 1'b1, RED);
        set_rect(1, 0, 0, 0, 0, 1'b0, GREEN);
        apply_inputs();
        do_latch();
        add(105, 240, RED);
        run_table();
        rx[0] = 300;
        apply_inputs();
        add(105, 241, RED); add(305, 242, BG); add(110, 299, RED); add(305, 299, BG);
        run_table();
        do_latch();
        add(105, 250, BG); add(305, 250, RED);
        run_table();

        // boundaries: no wrap, zero width, offscreen black
        set_rect(0, 1020, 10, 15, 20, 1'b1, RED);
        set_rect(1, 5, 10, 0, 20, 1'b1, GREEN);
        set_rect(2, 630, 470, 50, 50, 1'b1, BLUE);
        apply_inputs();
        do_latch();
        for (int x = 0; x <= 10; x++) add(x, 15, BG);
        add(1023, 15, '0); add(639, 479, BLUE); add(640, 479, '0);
        add(639, 480, '0); add(630, 470, BLUE); add(629, 470, BG); add(800, 600, '0);
        run_table();

        // collision flags between rect 0 and rect 2
        set_rect(0, 300, 300, 10, 10, 1'b1, RED);
        set_rect(1, 500, 100, 10, 10, 1'b1, GREEN);
        set_rect(2, 305, 305, 10, 10, 1'b1, BLUE);
        apply_inputs();
        do_latch();
        add(307, 307, RED); add(312, 312, BLUE); add(505, 105, GREEN); add(302, 302, RED);
        run_table();
        do_latch();
`ifdef VGA_RECT_COMPOSITOR_COLLISION_EN
        check("collision_hit_frame", bus.o_collision, 3'b100);
`else
        check("collision_hit_frame", bus.o_collision, 3'b000);
`endif
        set_rect(2, 400, 400, 10, 10, 1'b1, BLUE);
        apply_inputs();
        add(307, 307, RED); add(312, 312, BLUE);
        run_table();
        do_latch();
        add(307, 307, RED); add(405, 405, BLUE);
        run_table();
        do_latch();
        check("collision_clear_frame", bus.o_collision, 3'b000);

        // randomized geometry and pixels against the model
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NR; k++) begin
                set_rect(k, $urandom_range(0, 700), $urandom_range(0, 520),
                         $urandom_range(0, 250), $urandom_range(0, 250),
                         1'($urandom_range(0, 4) != 0), CW'($urandom));
            end
            bg = CW'($urandom);
            apply_inputs();
            do_latch();
            for (int i = 0; i < 200; i++) begin
                int x, y;
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
                if (x == 0 && y == VA) x = 1;
                if (i == 100) begin
                    rx[0] = $urandom_range(0, 1023);
                    rw[1] = $urandom_range(0, 300);
                    apply_inputs();
                end
                step(x, y, 1'($urandom), 1'($urandom), 1'b0, '0);
            end
            do_latch();
        end

        // reset mid-frame: geometry cleared, background is 0 until a latch
        do_reset();
        set_rect(0, 100, 100, 50, 50, 1'b1, RED);
        bg = BG;
        apply_inputs();
        add(120, 120, '0); add(300, 300, '0); add(700, 10, '0);
        run_table();
        do_latch();
        add(120, 120, RED); add(300, 300, BG);
        run_table();
        pxm(1, 1);
        pxm(2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
